// File: rtl/game_pkg.sv
// Shared types and constants for the light-cycle game: BCD digit type,
// default clock rate and active-low 7-segment glyphs {g,f,e,d,c,b,a}.
package game_pkg;

  typedef logic [3:0] bcd_t;

  localparam int CLK_HZ = 50_000_000;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low 7-segment decoder, fully defined over 0-F.
// Shared by the match timer and the score display.
module seg7_decode
  import game_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_0;
    case (digit)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/match_timer_display.sv
// Movement tick generator and pausable MM:SS match timer shown on HEX3..HEX0.
// Both prescalers advance only on enabled cycles and resume where paused.
module match_timer_display
  import game_pkg::*;
#(
  parameter int CLK_HZ   = game_pkg::CLK_HZ,
  parameter int MOVE_DIV = 10_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  output logic       move_tick,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(CLK_HZ - 1);

  logic [MW-1:0] mcnt_r;
  logic [SW-1:0] scnt_r;
  logic          move_tick_r;
  bcd_t          s_ones_r, s_tens_r, m_ones_r, m_tens_r;
  logic          move_term_s, sec_pulse_s;

  assign move_term_s = enable && (mcnt_r == MOVE_LAST);
  assign sec_pulse_s = enable && (scnt_r == SEC_LAST);
  assign move_tick   = move_tick_r;

  // Prescalers, registered tick and the BCD MM:SS chain
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      mcnt_r      <= MW'(0);
      scnt_r      <= SW'(0);
      move_tick_r <= 1'b0;
      s_ones_r    <= 4'd0;
      s_tens_r    <= 4'd0;
      m_ones_r    <= 4'd0;
      m_tens_r    <= 4'd0;
    end else begin
      move_tick_r <= move_term_s;
      if (enable) begin
        mcnt_r <= move_term_s ? MW'(0) : mcnt_r + MW'(1);
        scnt_r <= sec_pulse_s ? SW'(0) : scnt_r + SW'(1);
      end
      // Carry ripples upward; 99:59 rolls over to 00:00
      if (sec_pulse_s) begin
        if (s_ones_r == 4'd9) begin
          s_ones_r <= 4'd0;
          if (s_tens_r == 4'd5) begin
            s_tens_r <= 4'd0;
            if (m_ones_r == 4'd9) begin
              m_ones_r <= 4'd0;
              m_tens_r <= (m_tens_r == 4'd9) ? 4'd0 : m_tens_r + 4'd1;
            end else begin
              m_ones_r <= m_ones_r + 4'd1;
            end
          end else begin
            s_tens_r <= s_tens_r + 4'd1;
          end
        end else begin
          s_ones_r <= s_ones_r + 4'd1;
        end
      end
    end
  end

  seg7_decode u_dec0 (.digit(s_ones_r), .seg(HEX0));
  seg7_decode u_dec1 (.digit(s_tens_r), .seg(HEX1));
  seg7_decode u_dec2 (.digit(m_ones_r), .seg(HEX2));
  seg7_decode u_dec3 (.digit(m_tens_r), .seg(HEX3));

endmodule

// File: tb/tb_match_timer_display.sv
// Self-checking bench for match_timer_display: phase table, hand sequences
// and random enable/reset traffic against an elapsed-enabled-cycles model.
module tb_match_timer_display;

  localparam int CLK_HZ   = 10;
  localparam int MOVE_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       enable   = 1'b0;
  logic       move_tick;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  match_timer_display #(.CLK_HZ(CLK_HZ), .MOVE_DIV(MOVE_DIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .enable   (enable),
    .move_tick(move_tick),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   e_cnt     = 0;   // enabled cycles since last reset
  logic exp_tick  = 1'b0;
  int   tick_seen = 0;

  typedef struct {
    logic        rn;
    logic        en;
    int          cycles;
    logic [15:0] exp_bcd;
    int          exp_ticks;
  } phase_t;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic cycle();
    int secs;
    @(posedge CLOCK_50);
    if (!resetn) begin
      e_cnt    = 0;
      exp_tick = 1'b0;
    end else if (enable) begin
      e_cnt++;
      exp_tick = ((e_cnt % MOVE_DIV) == 0);
    end else begin
      exp_tick = 1'b0;
    end
    #1;
    secs = (e_cnt / CLK_HZ) % 6000;
    check("move_tick", {31'd0, move_tick}, {31'd0, exp_tick});
    check("HEX0", {25'd0, HEX0}, {25'd0, seg_of(secs % 10)});
    check("HEX1", {25'd0, HEX1}, {25'd0, seg_of((secs % 60) / 10)});
    check("HEX2", {25'd0, HEX2}, {25'd0, seg_of((secs / 60) % 10)});
    check("HEX3", {25'd0, HEX3}, {25'd0, seg_of(secs / 600)});
    if (move_tick === 1'b1) tick_seen++;
  endtask

  task automatic run(input logic rn, input logic en, input int n);
    resetn = rn;
    enable = en;
    for (int k = 0; k < n; k++) cycle();
  endtask

  phase_t ph [15];

  initial begin
    logic [15:0] b;
    ph[0]  = '{1'b0, 1'b1, 2,     16'h0000, 0};
    ph[1]  = '{1'b1, 1'b1, 40,    16'h0004, 10};
    ph[2]  = '{1'b1, 1'b1, 60,    16'h0010, 15};
    ph[3]  = '{1'b1, 1'b0, 100,   16'h0010, 0};
    ph[4]  = '{1'b1, 1'b1, 5,     16'h0010, 1};
    ph[5]  = '{1'b1, 1'b1, 485,   16'h0059, 121};
    ph[6]  = '{1'b1, 1'b1, 10,    16'h0100, 3};
    ph[7]  = '{1'b0, 1'b1, 1,     16'h0000, 0};
    ph[8]  = '{1'b1, 1'b1, 370,   16'h0037, 92};
    ph[9]  = '{1'b0, 1'b1, 1,     16'h0000, 0};
    ph[10] = '{1'b1, 1'b1, 9,     16'h0000, 2};
    ph[11] = '{1'b1, 1'b1, 1,     16'h0001, 0};
    ph[12] = '{1'b0, 1'b0, 1,     16'h0000, 0};
    ph[13] = '{1'b1, 1'b1, 59990, 16'h9959, 14997};
    ph[14] = '{1'b1, 1'b1, 10,    16'h0000, 3};

    #2;
    for (int i = 0; i < 15; i++) begin
      tick_seen = 0;
      run(ph[i].rn, ph[i].en, ph[i].cycles);
      b = ph[i].exp_bcd;
      check($sformatf("phase%0d_display", i), {4'd0, HEX3, HEX2, HEX1, HEX0},
            {4'd0, seg_of(int'(b[15:12])), seg_of(int'(b[11:8])),
                   seg_of(int'(b[7:4])), seg_of(int'(b[3:0]))});
      check($sformatf("phase%0d_ticks", i), tick_seen, ph[i].exp_ticks);
    end

    // Enable drops right after the terminal-count edge: tick still fires, then silence.
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 4);
    check("tc_edge_tick", {31'd0, move_tick}, 32'd1);
    run(1'b1, 1'b0, 1);
    check("tc_edge_paused_tick", {31'd0, move_tick}, 32'd0);
    // Second boundary with enable falling just after it.
    run(1'b1, 1'b1, 6);
    check("sec_edge_hex0", {25'd0, HEX0}, {25'd0, 7'h79});
    run(1'b1, 1'b0, 3);
    check("sec_edge_held_hex0", {25'd0, HEX0}, {25'd0, 7'h79});

    // Random enable with occasional reset, checked cycle by cycle.
    for (int r = 0; r < 3000; r++) begin
      resetn = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
